param_up_down_counter: RTL and testbench

//  Parametrised synchronous up/down counter; generational successor to the fixed 3-bit counter.

---
 rtl/udc_pkg.sv | 21 ++
 rtl/udc_prescaler.sv | 33 +++
 rtl/param_up_down_counter.sv | 100 ++++++++++
 tb/tb_param_up_down_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
// Build option UDC_SATURATE_EN selects saturating instead of wrapping bounds.
package udc_pkg;

   typedef enum logic {
      UDC_DOWN = 1'b0,
      UDC_UP   = 1'b1
   } udc_dir_t;

   function automatic int udc_pcnt_w(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

   function automatic int unsigned udc_clamp(
      input int unsigned val,
      input int unsigned modulus
   );
      return (val < modulus) ? val : modulus - 1;
   endfunction

endpackage

// File: rtl/udc_prescaler.sv
// Divides enabled cycles down to one count step every PRESCALE enables.
// A synchronous clear (load) restarts the phase at zero.
module udc_prescaler
   import udc_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sync_clr,
   output logic step
);

   localparam int PCNT_W = udc_pcnt_w(PRESCALE);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

   logic [PCNT_W-1:0] pcnt;

   // With PRESCALE==1 pcnt is stuck at 0, so step reduces to en.
   assign step = en && (pcnt == PCNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (sync_clr || step) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= pcnt + PCNT_W'(1);
      end
   end

endmodule

// File: rtl/param_up_down_counter.sv
// Up/down counter with modulus, prescaler, load, terminal-count pulse and
// sticky ovf/unf flags. Define UDC_SATURATE_EN to hold at the bounds.
module param_up_down_counter
   import udc_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 2 ** WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             ovf,
   output logic             unf
);

   localparam logic [WIDTH:0]   MAX_W1 = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);

   logic             step;
   logic             at_max;
   logic             at_min;
   udc_dir_t         dir;
   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
   logic             ovf_set;
   logic             unf_set;

   udc_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_pre (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (load),
      .step     (step)
   );

   assign dir    = udc_dir_t'(up_down);
   assign at_max = ({1'b0, Q} == MAX_W1);
   assign at_min = (Q == '0);

   always_comb begin
      q_nxt   = Q;
      tc_nxt  = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (load) begin
         q_nxt = WIDTH'(udc_clamp(32'(load_val), MODULUS));
      end else if (step) begin
         if (dir == UDC_UP) begin
            if (at_max) begin
`ifdef UDC_SATURATE_EN
               q_nxt = MAX_Q;
`else
               q_nxt = '0;
`endif
               tc_nxt  = 1'b1;
               ovf_set = 1'b1;
            end else begin
               q_nxt = Q + WIDTH'(1);
            end
         end else begin
            if (at_min) begin
`ifdef UDC_SATURATE_EN
               q_nxt = '0;
`else
               q_nxt = MAX_Q;
`endif
               tc_nxt  = 1'b1;
               unf_set = 1'b1;
            end else begin
               q_nxt = Q - WIDTH'(1);
            end
         end
      end
   end

   // A flag set in the same cycle as clr_flags wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q   <= '0;
         tc  <= 1'b0;
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         Q   <= q_nxt;
         tc  <= tc_nxt;
         ovf <= ovf_set | (ovf & ~clr_flags);
         unf <= unf_set | (unf & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_param_up_down_counter.sv
// Directed bench: default, MODULUS=6 and PRESCALE=3 counters on shared inputs.
// Expectations follow UDC_SATURATE_EN when it is defined.
module tb_param_up_down_counter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       up_down;
   logic       load;
   logic [2:0] load_val;
   logic       clr_flags;

   logic [2:0] q0, q6, q3;
   logic       tc0, tc6, tc3;
   logic       ovf0, ovf6, ovf3;
   logic       unf0, unf6, unf3;

   int n_checks = 0;
   int n_errors = 0;

   param_up_down_counter u0 (
      .clk (clk), .rst_n (rst_n), .en (en), .up_down (up_down),
      .load (load), .load_val (load_val), .clr_flags (clr_flags),
      .Q (q0), .tc (tc0), .ovf (ovf0), .unf (unf0)
   );

   param_up_down_counter #(.WIDTH (3), .MODULUS (6)) u6 (
      .clk (clk), .rst_n (rst_n), .en (en), .up_down (up_down),
      .load (load), .load_val (load_val), .clr_flags (clr_flags),
      .Q (q6), .tc (tc6), .ovf (ovf6), .unf (unf6)
   );

   param_up_down_counter #(.WIDTH (3), .PRESCALE (3)) u3 (
      .clk (clk), .rst_n (rst_n), .en (en), .up_down (up_down),
      .load (load), .load_val (load_val), .clr_flags (clr_flags),
      .Q (q3), .tc (tc3), .ovf (ovf3), .unf (unf3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef UDC_SATURATE_EN
   int exp_up8[9]  = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
   int tc_up8[9]   = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
   int exp_dn[4]   = '{2, 1, 0, 0};
   int exp_m6[6]   = '{1, 2, 3, 4, 5, 5};
   int exp_sat7    = 7;
`else
   int exp_up8[9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
   int tc_up8[9]   = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
   int exp_dn[4]   = '{2, 1, 0, 7};
   int exp_m6[6]   = '{1, 2, 3, 4, 5, 0};
   int exp_sat7    = 0;
`endif
   int tc_dn[4]    = '{0, 0, 0, 1};
   int tc_m6[6]    = '{0, 0, 0, 0, 0, 1};
   int en_p3[11]   = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
   int exp_p3[11]  = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      up_down   = 1'b1;
      load      = 1'b0;
      load_val  = '0;
      clr_flags = 1'b0;
      tick();
      tick();
      chk("rst_q",   int'(q0),   0);
      chk("rst_tc",  int'(tc0),  0);
      chk("rst_ovf", int'(ovf0), 0);
      chk("rst_unf", int'(unf0), 0);
      chk("rst_q3",  int'(q3),   0);

      // up count through the top of the range
      rst_n = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("up_q%0d", i),  int'(q0),  exp_up8[i]);
         chk($sformatf("up_tc%0d", i), int'(tc0), tc_up8[i]);
      end
      chk("up_ovf", int'(ovf0), 1);
      chk("up_unf", int'(unf0), 0);

      // load 2, one step up, then reverse through zero
      load     = 1'b1;
      load_val = 3'd2;
      en       = 1'b0;
      tick();
      chk("ld2_q",  int'(q0),  2);
      chk("ld2_tc", int'(tc0), 0);
      load = 1'b0;
      en   = 1'b1;
      tick();
      chk("rev_q3", int'(q0), 3);
      up_down = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("dn_q%0d", i),  int'(q0),  exp_dn[i]);
         chk($sformatf("dn_tc%0d", i), int'(tc0), tc_dn[i]);
      end
      chk("dn_unf", int'(unf0), 1);
      chk("dn_ovf", int'(ovf0), 1);

      // asynchronous reset between edges
      en       = 1'b0;
      load     = 1'b1;
      load_val = 3'd5;
      tick();
      load = 1'b0;
      chk("pre_rst_q", int'(q0), 5);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_q",   int'(q0),   0);
      chk("arst_tc",  int'(tc0),  0);
      chk("arst_ovf", int'(ovf0), 0);
      chk("arst_unf", int'(unf0), 0);
      tick();
      rst_n   = 1'b1;
      en      = 1'b1;
      up_down = 1'b1;

      // MODULUS=6 range, plus first step of u0 after reset
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) chk("post_rst_q", int'(q0), 1);
         chk($sformatf("m6_q%0d", i),  int'(q6),  exp_m6[i]);
         chk($sformatf("m6_tc%0d", i), int'(tc6), tc_m6[i]);
      end
      chk("m6_ovf", int'(ovf6), 1);
      load     = 1'b1;
      load_val = 3'd7;
      tick();
      chk("m6_ld_q",   int'(q6),   5);
      chk("m6_ld_tc",  int'(tc6),  0);
      chk("m6_ld_ovf", int'(ovf6), 1);
      load = 1'b0;

      // PRESCALE=3 with a mid-phase enable gap
      rst_n = 1'b0;
      en    = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         en = logic'(en_p3[i]);
         tick();
         chk($sformatf("p3_q%0d", i), int'(q3), exp_p3[i]);
      end
      chk("p3_tc", int'(tc3), 0);

      // clr_flags racing a set, then a plain clear
      en       = 1'b0;
      load     = 1'b1;
      load_val = 3'd7;
      tick();
      load      = 1'b0;
      en        = 1'b1;
      up_down   = 1'b1;
      clr_flags = 1'b1;
      tick();
      chk("clr_set_ovf", int'(ovf0), 1);
      chk("clr_set_tc",  int'(tc0),  1);
      chk("clr_set_q",   int'(q0),   exp_sat7);
      en = 1'b0;
      tick();
      chk("clr_ovf", int'(ovf0), 0);
      chk("clr_tc",  int'(tc0),  0);
      clr_flags = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
